// File: rtl/interp_pkg.sv
// ----------------------------------------------------------------------------
// interp_pkg : shared constants, mode/health encodings and FSM states for interp
// Revision   : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

package interp_pkg;

  localparam logic [1:0] MODE_INTEGRATE = 2'd0;
  localparam logic [1:0] MODE_INTERP    = 2'd1;

  localparam int HLT_OVF  = 0;
  localparam int HLT_BUSY = 1;

  // Divider start to slope valid: one cycle per quotient bit of a 33-bit dividend, plus load.
  localparam int DIV_LAT = 34;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_FIRST = 3'd1,
    ST_DIVIDE     = 3'd2,
    ST_RAMP       = 3'd3,
    ST_HOLD       = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/interp_divider.sv
// ----------------------------------------------------------------------------
// interp_divider : signed restoring divider, one quotient bit per cycle.
//                  Positive divisor only; quotient truncates toward zero.
// Revision       : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module interp_divider import interp_pkg::*; #(
  parameter int W  = DIV_LAT - 1,
  parameter int VW = W - 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic signed [W-1:0] dividend,
  input  logic [VW-1:0]       divisor,
  output logic signed [W-1:0] quotient,
  output logic                done
);

  localparam int            CW   = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W);

  logic          busy;
  logic          neg;
  logic [CW-1:0] cnt;
  logic [W-1:0]  shreg;
  logic [VW-1:0] rem;
  logic [VW-1:0] dvs;
  logic [W-1:0]  mag;
  logic [VW:0]   trial;
  logic [VW:0]   diff;
  logic          fits;

  // shreg shifts the dividend magnitude out at the top while quotient bits enter at the bottom
  always_comb begin
    mag   = dividend[W-1] ? (~dividend + 1'b1) : dividend;
    trial = {rem, shreg[W-1]};
    diff  = trial - {1'b0, dvs};
    fits  = (trial >= {1'b0, dvs});
  end

  assign done     = busy && (cnt == LAST);
  assign quotient = neg ? -$signed(shreg) : $signed(shreg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= 1'b0;
      neg   <= 1'b0;
      cnt   <= '0;
      shreg <= '0;
      rem   <= '0;
      dvs   <= '0;
    end else if (abort) begin
      busy <= 1'b0;
    end else if (start) begin
      busy  <= 1'b1;
      neg   <= dividend[W-1];
      cnt   <= '0;
      shreg <= mag;
      rem   <= '0;
      dvs   <= divisor;
    end else if (busy) begin
      if (cnt == LAST) begin
        busy <= 1'b0;
      end else begin
        cnt   <= cnt + 1'b1;
        shreg <= {shreg[W-2:0], fits};
        rem   <= fits ? diff[VW-1:0] : trial[VW-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/interp.sv
// ----------------------------------------------------------------------------
// interp   : rebuilds a per-clock signal from a sparse sample stream by running
//            sum (INTEGRATE) or linear ramp between samples (INTERP).
//            Define INTERP_SAT_EN to saturate the INTEGRATE accumulator.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module interp import interp_pkg::*; #(
  parameter int DW = 32
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [1:0]           mode_i,
  input  logic                 enable_i,
  input  logic                 valid_i,
  input  logic signed [DW-1:0] inp_i,
  output logic signed [DW-1:0] out_o,
  output logic                 valid_o,
  output logic [1:0]           health_o
);

  localparam int QW = DW + 1;
  localparam int SW = DW + 2;

`ifdef INTERP_SAT_EN
  localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};
`endif

  state_t               state_q, state_d;
  logic                 en_q;
  logic [1:0]           mode_q, mode_d;
  logic signed [DW-1:0] out_d;
  logic                 valid_d;
  logic [1:0]           health_d;
  logic signed [DW-1:0] prev_q, prev_d;
  logic signed [QW-1:0] slope_q, slope_d;
  logic [DW-1:0]        cnt_q, cnt_d;
  logic [DW-1:0]        period;
  logic signed [QW-1:0] delta;
  logic signed [QW-1:0] sum;
  logic                 ovf;
  logic signed [QW-1:0] step_slope;
  logic signed [SW-1:0] step_val;
  logic signed [SW-1:0] tgt_ext;
  logic                 reach;
  logic                 rise;
  logic                 div_start;
  logic                 div_abort;
  logic                 div_done;
  logic signed [QW-1:0] div_quot;

  assign rise      = enable_i & ~en_q;
  assign div_abort = ~enable_i | rise;
  assign period    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign delta     = {inp_i[DW-1], inp_i} - {prev_q[DW-1], prev_q};
  assign sum       = {out_o[DW-1], out_o} + {inp_i[DW-1], inp_i};
  assign ovf       = sum[QW-1] ^ sum[DW-1];

  // prev_q doubles as the ramp target; the first ramp step uses the fresh quotient
  assign step_slope = (state_q == ST_DIVIDE) ? div_quot : slope_q;
  assign step_val   = {{2{out_o[DW-1]}}, out_o} + {step_slope[QW-1], step_slope};
  assign tgt_ext    = {{2{prev_q[DW-1]}}, prev_q};
  assign reach      = step_slope[QW-1] ? (step_val <= tgt_ext) : (step_val >= tgt_ext);

  interp_divider #(.W(QW), .VW(DW)) u_div (
    .clk      (clk_i),
    .rst      (reset_i),
    .start    (div_start),
    .abort    (div_abort),
    .dividend (delta),
    .divisor  (period),
    .quotient (div_quot),
    .done     (div_done)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    out_d     = out_o;
    valid_d   = 1'b0;
    health_d  = health_o;
    prev_d    = prev_q;
    slope_d   = slope_q;
    cnt_d     = cnt_q;
    div_start = 1'b0;

    if (!enable_i) begin
      state_d = ST_IDLE;
    end else if (rise) begin
      state_d  = ST_WAIT_FIRST;
      mode_d   = mode_i;
      out_d    = '0;
      health_d = '0;
      cnt_d    = '0;
    end else if (mode_q != MODE_INTERP) begin
      // out_o is the accumulator; reserved modes fall through here
      if (valid_i) begin
        valid_d = 1'b1;
        if (ovf) health_d[HLT_OVF] = 1'b1;
`ifdef INTERP_SAT_EN
        if (ovf) out_d = sum[QW-1] ? SAT_MIN : SAT_MAX;
        else     out_d = sum[DW-1:0];
`else
        out_d = sum[DW-1:0];
`endif
      end
    end else begin
      cnt_d = period;
      case (state_q)
        ST_WAIT_FIRST: begin
          if (valid_i) begin
            state_d = ST_HOLD;
            out_d   = inp_i;
            prev_d  = inp_i;
            valid_d = 1'b1;
            cnt_d   = '0;
          end
        end
        ST_HOLD, ST_RAMP, ST_DIVIDE: begin
          if (valid_i) begin
            state_d   = ST_DIVIDE;
            out_d     = prev_q;
            prev_d    = inp_i;
            valid_d   = 1'b1;
            cnt_d     = '0;
            div_start = 1'b1;
            if (state_q == ST_DIVIDE) health_d[HLT_BUSY] = 1'b1;
          end else if ((state_q == ST_DIVIDE && div_done) || state_q == ST_RAMP) begin
            if (state_q == ST_DIVIDE) slope_d = div_quot;
            if (step_slope == '0) begin
              state_d = ST_HOLD;
            end else begin
              valid_d = 1'b1;
              if (reach) begin
                state_d = ST_HOLD;
                out_d   = prev_q;
              end else begin
                state_d = ST_RAMP;
                out_d   = step_val[DW-1:0];
              end
            end
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      mode_q   <= MODE_INTEGRATE;
      out_o    <= '0;
      valid_o  <= 1'b0;
      health_o <= '0;
      prev_q   <= '0;
      slope_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= enable_i;
      mode_q   <= mode_d;
      out_o    <= out_d;
      valid_o  <= valid_d;
      health_o <= health_d;
      prev_q   <= prev_d;
      slope_q  <= slope_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

`default_nettype wire
